// File: rtl/insn_buffer_ctrl.sv
// Instruction buffer between fetch and decode.
// Holds 16-bit halfword entries in a circular array. Fetch pushes one or two
// entries per accepted word, and decode pops one or two entries per cycle.
// The oldest two entries are presented combinationally as low/high.
module insn_buffer_ctrl #(
  parameter int ENTRY_COUNT    = 8,
  parameter int INT_CODE_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               write_valid,
  output logic                               write_ready,
  input  logic [31:0]                        write_pc,
  input  logic [31:0]                        write_insn,
  input  logic                               write_skip_low,
  input  logic                               write_fault,
  input  logic                               write_int_valid,
  input  logic [INT_CODE_WIDTH-1:0]          write_int_code,
  input  logic                               read_low,
  input  logic                               read_high,
  output logic [$clog2(ENTRY_COUNT+1)-1:0]   readable_count,
  output logic [15:0]                        low_insn,
  output logic [15:0]                        high_insn,
  output logic [31:0]                        low_pc,
  output logic [31:0]                        high_pc,
  output logic                               low_fault,
  output logic                               high_fault,
  output logic                               low_int_valid,
  output logic                               high_int_valid,
  output logic [INT_CODE_WIDTH-1:0]          low_int_code,
  output logic [INT_CODE_WIDTH-1:0]          high_int_code
);

  localparam int PTR_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = $clog2(ENTRY_COUNT + 1);

  typedef struct packed {
    logic [15:0]               insn;
    logic [31:0]               pc;
    logic                      fault;
    logic                      int_valid;
    logic [INT_CODE_WIDTH-1:0] int_code;
  } entry_t;

  entry_t mem [ENTRY_COUNT];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_plus1;
  logic [PTR_W-1:0] wr_ptr_plus1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] pop_req;
  logic [CNT_W-1:0] pops;
  logic [CNT_W-1:0] written;
  logic [CNT_W:0]   count_sum;
  logic [CNT_W-1:0] count_next;
  logic             accept;

  entry_t first_entry;
  entry_t second_entry;
  entry_t low_entry;
  entry_t high_entry;

  assign rd_ptr_plus1 = rd_ptr + PTR_W'(1);
  assign wr_ptr_plus1 = wr_ptr + PTR_W'(1);

  // Back-pressure looks only at registered occupancy; a same-cycle pop never frees room.
  always_comb begin
    free_slots  = CNT_W'(ENTRY_COUNT) - count;
    write_ready = (free_slots >= CNT_W'(2));
    accept      = write_valid & write_ready & ~flush;
  end

  // Build the one or two entries produced by the incoming fetch word.
  always_comb begin
    first_entry  = '0;
    second_entry = '0;
    if (write_skip_low) begin
      first_entry.insn = write_insn[31:16];
      first_entry.pc   = write_pc + 32'd2;
    end else begin
      first_entry.insn = write_insn[15:0];
      first_entry.pc   = write_pc;
    end
    first_entry.fault     = write_fault;
    first_entry.int_valid = write_int_valid;
    // A code with no interrupt attached would be meaningless, so it is stored as zero.
    first_entry.int_code  = write_int_valid ? write_int_code : '0;

    second_entry.insn      = write_insn[31:16];
    second_entry.pc        = write_pc + 32'd2;
    second_entry.fault     = write_fault;
    second_entry.int_valid = 1'b0;
    second_entry.int_code  = '0;
  end

  // Entry and pop accounting; decode may over-ask and is clamped to what is held.
  always_comb begin
    if (read_low) begin
      pop_req = read_high ? CNT_W'(2) : CNT_W'(1);
    end else begin
      pop_req = '0;
    end
    pops = (pop_req > count) ? count : pop_req;

    if (accept) begin
      written = write_skip_low ? CNT_W'(1) : CNT_W'(2);
    end else begin
      written = '0;
    end

    count_sum  = {1'b0, count} + {1'b0, written} - {1'b0, pops};
    count_next = count_sum[CNT_W-1:0];
  end

  // Pointer and occupancy registers; flush wins over any same-cycle write or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pops);
      wr_ptr <= wr_ptr + PTR_W'(written);
      count  <= count_next;
    end
  end

  // Entry storage; flush leaves stale contents because count=0 hides them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      mem[wr_ptr] <= first_entry;
      if (!write_skip_low) begin
        mem[wr_ptr_plus1] <= second_entry;
      end
    end
  end

  // Present the two oldest entries, masked to zero when not actually held.
  always_comb begin
    low_entry  = (count >= CNT_W'(1)) ? mem[rd_ptr]       : '0;
    high_entry = (count >= CNT_W'(2)) ? mem[rd_ptr_plus1] : '0;
  end

  assign readable_count = count;

  assign low_insn       = low_entry.insn;
  assign low_pc         = low_entry.pc;
  assign low_fault      = low_entry.fault;
  assign low_int_valid  = low_entry.int_valid;
  assign low_int_code   = low_entry.int_code;

  assign high_insn      = high_entry.insn;
  assign high_pc        = high_entry.pc;
  assign high_fault     = high_entry.fault;
  assign high_int_valid = high_entry.int_valid;
  assign high_int_code  = high_entry.int_code;

  // Occupancy must stay within 0..ENTRY_COUNT; an underflow would wrap to a large value.
  assert property (@(posedge clk) disable iff (!rst)
    count_sum <= (CNT_W+1)'(ENTRY_COUNT));

endmodule

// File: tb/tb_insn_buffer_ctrl.sv
// Bench for insn_buffer_ctrl: table of stimulus vectors with post-cycle
// expectations, plus a queue model of the buffer whose head is compared
// against the DUT low/high outputs every cycle.
module tb_insn_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        write_valid = 1'b0;
  logic        write_ready;
  logic [31:0] write_pc = '0;
  logic [31:0] write_insn = '0;
  logic        write_skip_low = 1'b0;
  logic        write_fault = 1'b0;
  logic        write_int_valid = 1'b0;
  logic [3:0]  write_int_code = '0;
  logic        read_low = 1'b0;
  logic        read_high = 1'b0;
  logic [3:0]  readable_count;
  logic [15:0] low_insn, high_insn;
  logic [31:0] low_pc, high_pc;
  logic        low_fault, high_fault;
  logic        low_int_valid, high_int_valid;
  logic [3:0]  low_int_code, high_int_code;

  insn_buffer_ctrl #(.ENTRY_COUNT(8), .INT_CODE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_pc(write_pc), .write_insn(write_insn), .write_skip_low(write_skip_low),
    .write_fault(write_fault), .write_int_valid(write_int_valid), .write_int_code(write_int_code),
    .read_low(read_low), .read_high(read_high), .readable_count(readable_count),
    .low_insn(low_insn), .high_insn(high_insn), .low_pc(low_pc), .high_pc(high_pc),
    .low_fault(low_fault), .high_fault(high_fault),
    .low_int_valid(low_int_valid), .high_int_valid(high_int_valid),
    .low_int_code(low_int_code), .high_int_code(high_int_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] insn;
    logic [31:0] pc;
    logic        f;
    logic        iv;
    logic [3:0]  ic;
  } ent_t;

  typedef struct packed {
    logic        fl;
    logic        wv;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        sk;
    logic        fault;
    logic        iv;
    logic [3:0]  ic;
    logic        rl;
    logic        rh;
    logic        chk;
    logic [3:0]  e_cnt;
    logic        e_wr;
    logic [15:0] e_li;
    logic [31:0] e_lpc;
    logic [15:0] e_hi;
    logic [31:0] e_hpc;
    logic        chk_tag;
    logic [11:0] e_tag;
  } vec_t;

  ent_t q[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic fl, logic wv, logic [31:0] pc, logic [31:0] insn,
                              logic sk, logic rl, logic rh);
    vec_t v;
    v = '0;
    v.fl = fl; v.wv = wv; v.pc = pc; v.insn = insn; v.sk = sk; v.rl = rl; v.rh = rh;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vin, logic [3:0] cnt, logic wr, logic [15:0] li,
                              logic [31:0] lpc, logic [15:0] hi, logic [31:0] hpc);
    vec_t v;
    v = vin;
    v.chk = 1'b1; v.e_cnt = cnt; v.e_wr = wr;
    v.e_li = li; v.e_lpc = lpc; v.e_hi = hi; v.e_hpc = hpc;
    return v;
  endfunction

  function automatic ent_t low_act();
    return {low_insn, low_pc, low_fault, low_int_valid, low_int_code};
  endfunction

  function automatic ent_t high_act();
    return {high_insn, high_pc, high_fault, high_int_valid, high_int_code};
  endfunction

  // Compare DUT read side against the model queue head (pre-edge view).
  task automatic check_model();
    ent_t el, eh;
    el = (q.size() >= 1) ? q[0] : '0;
    eh = (q.size() >= 2) ? q[1] : '0;
    chk("model_count", 64'(readable_count), 64'(q.size()));
    chk("model_write_ready", 64'(write_ready), 64'(q.size() <= 6));
    chk("model_low_entry", 64'(low_act()), 64'(el));
    chk("model_high_entry", 64'(high_act()), 64'(eh));
  endtask

  // Advance the model by one clock edge with the inputs in v.
  task automatic model_step(vec_t v);
    int   req, pops;
    bit   acc;
    ent_t e;
    req  = v.rl ? (v.rh ? 2 : 1) : 0;
    pops = (req > q.size()) ? q.size() : req;
    acc  = v.wv && (q.size() <= 6) && !v.fl;
    if (v.fl) begin
      q.delete();
    end else begin
      for (int i = 0; i < pops; i++) void'(q.pop_front());
      if (acc) begin
        e.insn = v.sk ? v.insn[31:16] : v.insn[15:0];
        e.pc   = v.sk ? v.pc + 32'd2 : v.pc;
        e.f    = v.fault;
        e.iv   = v.iv;
        e.ic   = v.iv ? v.ic : 4'd0;
        q.push_back(e);
        if (!v.sk) begin
          e.insn = v.insn[31:16];
          e.pc   = v.pc + 32'd2;
          e.iv   = 1'b0;
          e.ic   = 4'd0;
          q.push_back(e);
        end
      end
    end
  endtask

  // Called at a negedge: drive, check pre-state, clock, then check table expectations.
  task automatic run_vec(vec_t v, int idx);
    flush = v.fl; write_valid = v.wv; write_pc = v.pc; write_insn = v.insn;
    write_skip_low = v.sk; write_fault = v.fault; write_int_valid = v.iv;
    write_int_code = v.ic; read_low = v.rl; read_high = v.rh;
    #1;
    check_model();
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    if (v.chk) begin
      chk($sformatf("v%0d_count", idx), 64'(readable_count), 64'(v.e_cnt));
      chk($sformatf("v%0d_write_ready", idx), 64'(write_ready), 64'(v.e_wr));
      chk($sformatf("v%0d_low", idx), 64'({low_insn, low_pc}), 64'({v.e_li, v.e_lpc}));
      chk($sformatf("v%0d_high", idx), 64'({high_insn, high_pc}), 64'({v.e_hi, v.e_hpc}));
    end
    if (v.chk_tag) begin
      chk($sformatf("v%0d_tags", idx),
          64'({low_fault, low_int_valid, low_int_code, high_fault, high_int_valid, high_int_code}),
          64'(v.e_tag));
    end
  endtask

  initial begin
    vec_t v;

    // Basic word write and full pop
    tbl.push_back(ex(mk(0, 1, 32'h1000, 32'h00A3_0513, 0, 0, 0), 2, 1, 16'h0513, 32'h1000, 16'h00A3, 32'h1002));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0));
    // Skip-low write leaves only the high halfword
    tbl.push_back(ex(mk(0, 1, 32'h2000, 32'h4501_BEEF, 1, 0, 0), 1, 1, 16'h4501, 32'h2002, 0, 0));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 0), 0, 1, 0, 0, 0, 0));
    // Fill to full
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 32'h3000 + 32'(4*k), {16'hB000 + 16'(k), 16'hA000 + 16'(k)}, 0, 0, 0));
    tbl.push_back(ex(mk(0, 1, 32'h300C, 32'hB003_A003, 0, 0, 0), 8, 0, 16'hA000, 32'h3000, 16'hB000, 32'h3002));
    // Write offered while full with a double pop: rejected, no read-to-write bypass
    tbl.push_back(ex(mk(0, 1, 32'h4000, 32'hFFFF_EEEE, 0, 1, 1), 6, 1, 16'hA001, 32'h3004, 16'hB001, 32'h3006));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 1), 4, 1, 16'hA002, 32'h3008, 16'hB002, 32'h300A));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0));
    // Fault and interrupt tagging
    v = ex(mk(0, 1, 32'h5000, 32'hAAAA_5555, 0, 0, 0), 2, 1, 16'h5555, 32'h5000, 16'hAAAA, 32'h5002);
    v.fault = 1; v.iv = 1; v.ic = 4'd7; v.chk_tag = 1;
    v.e_tag = {1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd0};
    tbl.push_back(v);
    // Flush with a write and a pop in the same cycle
    tbl.push_back(ex(mk(1, 1, 32'h6000, 32'hDEAD_BEEF, 0, 1, 0), 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0));
    // Walk pointers around the ring until rd_ptr sits at the last slot
    tbl.push_back(ex(mk(0, 1, 32'h7000, 32'h7777_1111, 1, 0, 0), 1, 1, 16'h7777, 32'h7002, 0, 0));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 0), 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++) begin
      tbl.push_back(ex(mk(0, 1, 32'h7100 + 32'(4*k), {16'hC000 + 16'(k), 16'hD000 + 16'(k)}, 0, 0, 0),
                       2, 1, 16'hD000 + 16'(k), 32'h7100 + 32'(4*k), 16'hC000 + 16'(k), 32'h7102 + 32'(4*k)));
      tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0));
    end
    // rd_ptr = 7: high comes from entry 0
    tbl.push_back(ex(mk(0, 1, 32'h7200, 32'h1234_5678, 0, 0, 0), 2, 1, 16'h5678, 32'h7200, 16'h1234, 32'h7202));
    // read_high alone pops nothing
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 0, 1), 2, 1, 16'h5678, 32'h7200, 16'h1234, 32'h7202));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 0), 1, 1, 16'h1234, 32'h7202, 0, 0));
    // Over-pop clamps at count, then pop on empty stays empty
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 0, 0, 0, 1, 0), 0, 1, 0, 0, 0, 0));
    // Seven entries: one free slot is still not enough for a word
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 1, 32'h8000 + 32'(4*k), {16'hE000 + 16'(k), 16'hF000 + 16'(k)}, 0, 0, 0));
    tbl.push_back(ex(mk(0, 1, 32'h800C, 32'hE003_F003, 1, 0, 0), 7, 0, 16'hF000, 32'h8000, 16'hE000, 32'h8002));
    tbl.push_back(ex(mk(0, 1, 32'h9000, 32'h9999_9999, 0, 1, 0), 6, 1, 16'hE000, 32'h8002, 16'hF001, 32'h8004));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("in_reset_count", 64'(readable_count), 64'd0);
    chk("in_reset_low", 64'(low_act()), 64'd0);
    rst = 1'b1;
    #1;
    chk("reset_count", 64'(readable_count), 64'd0);
    chk("reset_write_ready", 64'(write_ready), 64'd1);
    chk("reset_low", 64'(low_act()), 64'd0);
    chk("reset_high", 64'(high_act()), 64'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Asynchronous reset mid-operation clears occupancy without a clock edge
    run_vec(mk(0, 1, 32'hA000, 32'h2222_3333, 0, 0, 0), 100);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_count", 64'(readable_count), 64'd0);
    chk("async_reset_low", 64'(low_act()), 64'd0);
    chk("async_reset_high", 64'(high_act()), 64'd0);
    chk("async_reset_write_ready", 64'(write_ready), 64'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_vec(ex(mk(0, 1, 32'hB000, 32'h4444_5555, 0, 0, 0), 2, 1, 16'h5555, 32'hB000, 16'h4444, 32'hB002), 101);
    run_vec(ex(mk(0, 0, 0, 0, 0, 1, 1), 0, 1, 0, 0, 0, 0), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
